pmem_responder: RTL and testbench

//  Physical-memory responder: the far end of the cache's pmem_read/pmem_write/pmem_resp

---
 rtl/lc3b_types.sv | 10 +
 rtl/pmem_responder_if.sv | 22 ++
 rtl/pmem_line_array.sv | 23 ++
 rtl/pmem_responder.sv | 116 +++++++++++
 tb/tb_pmem_responder.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b word/line types and physical-memory constants.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    localparam int PMEM_LINE_OFFSET_BITS = 4;
    localparam int PMEM_DEFAULT_LATENCY  = 4;

endpackage

// File: rtl/pmem_responder_if.sv
// Cache-to-physical-memory line interface (pmem_read/pmem_write/pmem_resp).
interface pmem_responder_if;
    import lc3b_types::*;

    logic     pmem_read;
    logic     pmem_write;
    lc3b_word pmem_address;
    lc3b_line pmem_wdata;
    lc3b_line pmem_rdata;
    logic     pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/pmem_line_array.sv
// Line storage: one shared address, synchronous write, asynchronous read.
module pmem_line_array
    import lc3b_types::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  lc3b_line      wdata,
    output lc3b_line      rdata
);

    lc3b_line mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency line memory behind the cache pmem port.
// Define PMEM_PROTO_CHECK_EN to add the sticky proto_err output.
module pmem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY = PMEM_DEFAULT_LATENCY,
    parameter int DEPTH   = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    pmem_responder_if.slave    pmem
`ifdef PMEM_PROTO_CHECK_EN
    ,output logic              proto_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_n;
    logic [7:0]    cnt, cnt_n;
    logic          op_wr, op_wr_n;
    logic [AW-1:0] idx, idx_n;
    lc3b_line      wdata_q, wdata_n;
    lc3b_line      rdata_q, arr_rdata;
    logic          resp_q;
    logic          req, accept, abort, arr_we;
    logic          addr_unused;

    assign req         = pmem.pmem_read | pmem.pmem_write;
    assign addr_unused = ^pmem.pmem_address;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_wr_n = op_wr;
        idx_n   = idx;
        wdata_n = wdata_q;
        accept  = 1'b0;
        abort   = 1'b0;
        unique case (state)
            IDLE: if (req) begin
                accept  = 1'b1;
                op_wr_n = pmem.pmem_write;
                idx_n   = pmem.pmem_address[PMEM_LINE_OFFSET_BITS +: AW];
                wdata_n = pmem.pmem_wdata;
                cnt_n   = LAT_M1;
                state_n = (LATENCY == 1) ? RESP : BUSY;
            end
            BUSY: if (!req) begin
                abort   = 1'b1;
                cnt_n   = 8'd0;
                state_n = IDLE;
            end else begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) state_n = RESP;
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            op_wr   <= 1'b0;
            idx     <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            op_wr   <= op_wr_n;
            idx     <= idx_n;
            wdata_q <= wdata_n;
            resp_q  <= (state_n == RESP);
            // rdata only moves on a read completion and is held otherwise
            if (state_n == RESP && !op_wr_n) rdata_q <= arr_rdata;
        end
    end

    // A write lands at the edge leaving RESP, unless reset drops it
    assign arr_we = reset_n && (state == RESP) && op_wr;

    pmem_line_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (idx_n),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign pmem.pmem_resp  = resp_q;
    assign pmem.pmem_rdata = rdata_q;

`ifdef PMEM_PROTO_CHECK_EN
    lc3b_word addr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q    <= '0;
            proto_err <= 1'b0;
        end else begin
            if (accept) addr_q <= pmem.pmem_address;
            if ((accept && pmem.pmem_read && pmem.pmem_write) || abort ||
                (state == BUSY && pmem.pmem_address != addr_q))
                proto_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder (LATENCY=4 and LATENCY=1 instances).
module tb_pmem_responder;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pmem_responder_if bus ();
    pmem_responder_if bus1 ();

`ifdef PMEM_PROTO_CHECK_EN
    logic proto_err, proto_err1;
`endif

    pmem_responder #(.LATENCY(4), .DEPTH(256)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pmem    (bus.slave)
`ifdef PMEM_PROTO_CHECK_EN
        ,.proto_err (proto_err)
`endif
    );

    pmem_responder #(.LATENCY(1), .DEPTH(256)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .pmem    (bus1.slave)
`ifdef PMEM_PROTO_CHECK_EN
        ,.proto_err (proto_err1)
`endif
    );

    localparam lc3b_line L_12 = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    localparam lc3b_line L_AA = {16{8'hAA}};
    localparam lc3b_line L_55 = {16{8'h55}};
    localparam lc3b_line L_RS = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam lc3b_line L_W1 = 128'h0101_0101_0101_0101_0101_0101_0101_0101;
    localparam lc3b_line L_W2 = 128'h0202_0202_0202_0202_0202_0202_0202_0202;
    localparam lc3b_line L_G  = 128'hC0DE_C0DE_C0DE_C0DE_BEEF_BEEF_BEEF_BEEF;

    // One transaction on the LATENCY=4 instance; lat=-1 on timeout
    task automatic xact(input logic rd, input logic wr, input lc3b_word a,
                        input lc3b_line d, input bit glitch,
                        output int lat, output lc3b_line q);
        @(posedge clk); #1;
        bus.pmem_read = rd;
        bus.pmem_write = wr;
        bus.pmem_address = a;
        bus.pmem_wdata = d;
        lat = -1;
        q = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (bus.pmem_resp) begin
                lat = n;
                q = bus.pmem_rdata;
                break;
            end
            if (glitch && n == 2) begin
                bus.pmem_address = a ^ 16'h0400;
                bus.pmem_wdata = ~d;
            end
        end
        bus.pmem_read = 1'b0;
        bus.pmem_write = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.pmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp got=%b exp=0", bus.pmem_resp);
        end
        checks++;
        if (bus.pmem_rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", bus.pmem_rdata);
        end
`ifdef PMEM_PROTO_CHECK_EN
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_proto got=%b exp=0", proto_err);
        end
`endif
        reset_n = 1'b1;
    endtask

    task automatic test_write_read;
        int lat;
        lc3b_line q;
        xact(1'b0, 1'b1, 16'h0040, L_12, 1'b0, lat, q);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL wr_latency got=%0d exp=4", lat);
        end
        checks++;
        if (q !== '0) begin
            failures++;
            $display("FAIL wr_rdata_held got=%h exp=0", q);
        end
        xact(1'b1, 1'b0, 16'h004F, '0, 1'b0, lat, q);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL rd_latency got=%0d exp=4", lat);
        end
        checks++;
        if (q !== L_12) begin
            failures++;
            $display("FAIL rd_data got=%h exp=%h", q, L_12);
        end
    endtask

    task automatic test_lat1;
        logic [5:0] pat;
        @(posedge clk); #1;
        bus1.pmem_read = 1'b1;
        bus1.pmem_address = 16'h0000;
        pat = '0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            pat[n-1] = bus1.pmem_resp;
        end
        bus1.pmem_read = 1'b0;
        checks++;
        if (pat[0] !== 1'b1) begin
            failures++;
            $display("FAIL lat1_first got=%b exp=1", pat[0]);
        end
        checks++;
        if (pat !== 6'b010101) begin
            failures++;
            $display("FAIL lat1_b2b got=%b exp=010101", pat);
        end
    endtask

    task automatic test_rw_both;
        int lat;
        lc3b_line q;
        xact(1'b1, 1'b1, 16'h0100, L_AA, 1'b0, lat, q);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL rw_latency got=%0d exp=4", lat);
        end
        xact(1'b1, 1'b0, 16'h0100, '0, 1'b0, lat, q);
        checks++;
        if (q !== L_AA) begin
            failures++;
            $display("FAIL rw_data got=%h exp=%h", q, L_AA);
        end
`ifdef PMEM_PROTO_CHECK_EN
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL rw_proto got=%b exp=1", proto_err);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        lc3b_line q;
        xact(1'b0, 1'b1, 16'h0200, L_55, 1'b0, lat, q);
        @(posedge clk); #1;
        bus.pmem_write = 1'b1;
        bus.pmem_address = 16'h0200;
        bus.pmem_wdata = L_RS;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        bus.pmem_write = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.pmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_resp got=%b exp=0", bus.pmem_resp);
        end
        checks++;
        if (bus.pmem_rdata !== '0) begin
            failures++;
            $display("FAIL rst_mid_rdata got=%h exp=0", bus.pmem_rdata);
        end
`ifdef PMEM_PROTO_CHECK_EN
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_proto got=%b exp=0", proto_err);
        end
`endif
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.pmem_resp) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_mid_noresp got=%0d exp=0", seen);
        end
        xact(1'b1, 1'b0, 16'h0200, '0, 1'b0, lat, q);
        checks++;
        if (q !== L_55) begin
            failures++;
            $display("FAIL rst_mid_old got=%h exp=%h", q, L_55);
        end
    endtask

    task automatic test_abort;
        int lat;
        int seen;
        lc3b_line q;
        @(posedge clk); #1;
        bus.pmem_read = 1'b1;
        bus.pmem_address = 16'h0080;
        repeat (2) @(posedge clk);
        #1;
        bus.pmem_read = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.pmem_resp) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_noresp got=%0d exp=0", seen);
        end
        xact(1'b0, 1'b1, 16'h0080, L_W1, 1'b0, lat, q);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL abort_next_wr got=%0d exp=4", lat);
        end
`ifdef PMEM_PROTO_CHECK_EN
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL abort_proto got=%b exp=1", proto_err);
        end
`endif
    endtask

    task automatic test_glitch;
        int lat;
        lc3b_line q;
        xact(1'b0, 1'b1, 16'h0300, L_G, 1'b1, lat, q);
        xact(1'b1, 1'b0, 16'h0300, '0, 1'b0, lat, q);
        checks++;
        if (q !== L_G) begin
            failures++;
            $display("FAIL glitch_data got=%h exp=%h", q, L_G);
        end
        xact(1'b1, 1'b0, 16'h0700, '0, 1'b0, lat, q);
        checks++;
        if (q === ~L_G) begin
            failures++;
            $display("FAIL glitch_other got=%h exp=not %h", q, ~L_G);
        end
    endtask

    task automatic test_wrap;
        int lat;
        lc3b_line q;
        xact(1'b0, 1'b1, 16'h0010, L_W1, 1'b0, lat, q);
        xact(1'b0, 1'b1, 16'h1010, L_W2, 1'b0, lat, q);
        xact(1'b1, 1'b0, 16'h0010, '0, 1'b0, lat, q);
        checks++;
        if (q !== L_W2) begin
            failures++;
            $display("FAIL wrap_low got=%h exp=%h", q, L_W2);
        end
        xact(1'b1, 1'b0, 16'h0080, '0, 1'b0, lat, q);
        checks++;
        if (q !== L_W1) begin
            failures++;
            $display("FAIL wrap_other got=%h exp=%h", q, L_W1);
        end
    endtask

    initial begin
        bus.pmem_read = 1'b0;
        bus.pmem_write = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata = '0;
        bus1.pmem_read = 1'b0;
        bus1.pmem_write = 1'b0;
        bus1.pmem_address = '0;
        bus1.pmem_wdata = '0;
        test_reset;
        test_write_read;
        test_lat1;
        test_rw_both;
        test_reset_mid;
        test_abort;
        test_glitch;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
